// File: rtl/run_dump_controller_pkg.sv
// Shared constants for the end-of-run capture engine:
// FSM encodings, stream tags and the halt opcode.
package run_dump_pkg;

   typedef enum logic [2:0] {
      RUN   = 3'd0,
      TRACE = 3'd1,
      REGS  = 3'd2,
      MEMS  = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam logic [2:0] ST_RUN   = RUN;
   localparam logic [2:0] ST_TRACE = TRACE;
   localparam logic [2:0] ST_REGS  = REGS;
   localparam logic [2:0] ST_MEMS  = MEMS;
   localparam logic [2:0] ST_DONE  = DONE;

   localparam logic [1:0] TAG_PC  = 2'd0;
   localparam logic [1:0] TAG_REG = 2'd1;
   localparam logic [1:0] TAG_MEM = 2'd2;

   localparam logic [31:0] HALT_INST = 32'h0;

endpackage

// File: rtl/run_dump_controller_if.sv
// Valid/ready dump stream carrying tagged beats
// from the capture engine to its consumer.
interface run_dump_controller_if #(
   parameter int WIDTH = 32
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_tag;
   logic             out_last;

   modport master (
      output out_valid, out_data, out_tag, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_data, out_tag, out_last,
      output out_ready
   );
endinterface

// File: rtl/run_dump_controller_trace_ring.sv
// Circular PC trace: saturating fill count and a read port
// indexed relative to the oldest stored entry.
module trace_ring #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_idx_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wp_q, wp_d;
   logic [AW:0]      count_q, count_d;
   logic [AW-1:0]    rd_ptr;

   always_comb begin
      wp_d    = wp_q;
      count_d = count_q;
      if (wr_en_i) begin
         wp_d = wp_q + 1'b1;
         if (count_q != (AW+1)'(DEPTH))
            count_d = count_q + 1'b1;
      end
   end

   // When full the low count bits wrap to 0, so wp itself is the oldest slot.
   assign rd_ptr    = wp_q - count_q[AW-1:0] + rd_idx_i;
   assign rd_data_o = mem_q[rd_ptr];
   assign count_o   = count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_i)
         mem_q[wp_q] <= wr_data_i;
   end

endmodule

// File: rtl/run_dump_controller.sv
// End-of-run capture: records a PC trace while running, then streams
// the trace, register file and a data-memory window on halt or timeout.
module run_dump_controller
   import run_dump_pkg::*;
#(
   parameter  int               WIDTH       = 32,
   parameter  int               NUM_REGS    = 32,
   parameter  logic [WIDTH-1:0] MEM_BASE    = 'h4000,
   parameter  int               MEM_WORDS   = 4,
   parameter  int               MEM_DW      = 8,
   parameter  int               TRACE_DEPTH = 16,
   parameter  int               MAX_CYCLES  = 64,
   localparam int               RW          = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      pc_i,
   input  logic [31:0]           inst_i,
   output logic [RW-1:0]         rf_addr_o,
   input  logic [WIDTH-1:0]      rf_data_i,
   output logic [WIDTH-1:0]      mem_addr_o,
   input  logic [MEM_DW-1:0]     mem_data_i,
   run_dump_controller_if.master out_if,
   output logic                  halted_o,
   output logic                  timeout_o,
   output logic                  done_o
);

   localparam int AW   = $clog2(TRACE_DEPTH);
   localparam int IM0  = (TRACE_DEPTH > NUM_REGS) ? TRACE_DEPTH : NUM_REGS;
   localparam int IMAX = (IM0 > MEM_WORDS) ? IM0 : MEM_WORDS;
   localparam int IW   = $clog2(IMAX + 1);
   localparam int CW   = $clog2(MAX_CYCLES + 1);

   logic [2:0]       state_q, state_d;
   logic [CW-1:0]    cycles_q, cycles_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             halted_q, halted_d;
   logic             timeout_q, timeout_d;
   logic             done_q, done_d;

   logic             run, is_halt, is_budget, fire;
   logic [AW:0]      count;
   logic [WIDTH-1:0] trace_data;

   assign run       = (state_q == ST_RUN);
   assign is_halt   = (inst_i == HALT_INST);
   assign is_budget = (cycles_q == CW'(MAX_CYCLES - 1));
   assign fire      = out_if.out_valid && out_if.out_ready;

   trace_ring #(
      .WIDTH (WIDTH),
      .DEPTH (TRACE_DEPTH)
   ) u_ring (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (run),
      .wr_data_i (pc_i),
      .rd_idx_i  (idx_q[AW-1:0]),
      .rd_data_o (trace_data),
      .count_o   (count)
   );

   always_comb begin
      state_d   = state_q;
      cycles_d  = cycles_q;
      idx_d     = idx_q;
      halted_d  = halted_q;
      timeout_d = timeout_q;
      done_d    = done_q;
      case (state_q)
         ST_RUN: begin
            cycles_d = cycles_q + 1'b1;
            if (is_halt || is_budget) begin
               state_d   = ST_TRACE;
               idx_d     = '0;
               halted_d  = is_halt;
               timeout_d = is_budget;
            end
         end
         ST_TRACE: if (fire) begin
            if (idx_q == IW'(count) - 1'b1) begin
               state_d = ST_REGS;
               idx_d   = '0;
            end else
               idx_d = idx_q + 1'b1;
         end
         ST_REGS: if (fire) begin
            if (idx_q == IW'(NUM_REGS - 1)) begin
               state_d = ST_MEMS;
               idx_d   = '0;
            end else
               idx_d = idx_q + 1'b1;
         end
         ST_MEMS: if (fire) begin
            if (idx_q == IW'(MEM_WORDS - 1)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else
               idx_d = idx_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      out_if.out_valid = 1'b0;
      out_if.out_data  = '0;
      out_if.out_tag   = TAG_PC;
      out_if.out_last  = 1'b0;
      rf_addr_o        = '0;
      mem_addr_o       = '0;
      unique case (1'b1)
         (state_q == ST_TRACE): begin
            out_if.out_valid = 1'b1;
            out_if.out_data  = trace_data;
         end
         (state_q == ST_REGS): begin
            out_if.out_valid = 1'b1;
            out_if.out_tag   = TAG_REG;
            rf_addr_o        = idx_q[RW-1:0];
            out_if.out_data  = rf_data_i;
         end
         (state_q == ST_MEMS): begin
            out_if.out_valid = 1'b1;
            out_if.out_tag   = TAG_MEM;
            mem_addr_o       = MEM_BASE + WIDTH'(idx_q);
            out_if.out_data  = WIDTH'(mem_data_i);
            out_if.out_last  = (idx_q == IW'(MEM_WORDS - 1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_RUN;
         cycles_q  <= '0;
         idx_q     <= '0;
         halted_q  <= 1'b0;
         timeout_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cycles_q  <= cycles_d;
         idx_q     <= idx_d;
         halted_q  <= halted_d;
         timeout_q <= timeout_d;
         done_q    <= done_d;
      end
   end

   assign halted_o  = halted_q;
   assign timeout_o = timeout_q;
   assign done_o    = done_q;

endmodule

// File: tb/tb_run_dump_controller.sv
// Randomized bench for run_dump_controller: an expected-beat queue built
// from the run history is checked against the stream every cycle.
module tb_run_dump_controller;

   localparam int MAXC  = 64;
   localparam int DEPTH = 16;
   localparam int NREG  = 32;
   localparam int MW    = 4;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  t;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc_i, inst_i, rf_data_i, mem_addr_o;
   logic [4:0]  rf_addr_o;
   logic [7:0]  mem_data_i;
   logic        halted_o, timeout_o, done_o;

   logic [31:0] rf [NREG];
   logic [7:0]  memw [MW];
   beat_t       q[$];

   int          vectors = 0;
   int          miscompares = 0;
   int          phase = 0;
   int          beats = 0;
   bit          exp_h, exp_t;
   bit          stalled = 0;
   logic [31:0] sd;
   logic [1:0]  st;
   logic        sl;
   int          mdl_len;
   logic [31:0] mdl_first, mdl_lastpc, mdl_reg2;

   run_dump_controller_if #(.WIDTH(32)) bus();

   run_dump_controller dut (
      .clk        (clk),
      .reset      (reset),
      .pc_i       (pc_i),
      .inst_i     (inst_i),
      .rf_addr_o  (rf_addr_o),
      .rf_data_i  (rf_data_i),
      .mem_addr_o (mem_addr_o),
      .mem_data_i (mem_data_i),
      .out_if     (bus),
      .halted_o   (halted_o),
      .timeout_o  (timeout_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   assign rf_data_i  = rf[rf_addr_o];
   assign mem_data_i = (mem_addr_o >= 32'h4000 && mem_addr_o < 32'h4004)
                       ? memw[mem_addr_o[1:0]] : 8'hEE;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (phase == 1) begin
         check("run_valid", 32'(bus.out_valid), 0);
         check("run_halted", 32'(halted_o), 0);
         check("run_timeout", 32'(timeout_o), 0);
         check("run_done", 32'(done_o), 0);
         stalled = 0;
      end else if (phase == 2) begin
         check("halted", 32'(halted_o), 32'(exp_h));
         check("timeout", 32'(timeout_o), 32'(exp_t));
         check("done", 32'(done_o), 32'(q.size() == 0));
         check("valid", 32'(bus.out_valid), 32'(q.size() != 0));
         if (q.size() != 0 && bus.out_valid) begin
            check("data", bus.out_data, q[0].d);
            check("tag", 32'(bus.out_tag), 32'(q[0].t));
            check("last", 32'(bus.out_last), 32'(q.size() == 1));
            if (stalled) begin
               check("stall_data", bus.out_data, sd);
               check("stall_tag", 32'(bus.out_tag), 32'(st));
               check("stall_last", 32'(bus.out_last), 32'(sl));
            end
            if (bus.out_ready) begin
               void'(q.pop_front());
               beats++;
               stalled = 0;
            end else begin
               stalled = 1;
               sd = bus.out_data;
               st = bus.out_tag;
               sl = bus.out_last;
            end
         end
      end else
         stalled = 0;
   end

   task automatic run_case(input int halt_at, input logic [31:0] base,
                           input int mode, input int abort_at,
                           input bit randpc);
      int stop, n, elapsed;
      logic [31:0] p;
      logic [31:0] pcs[$];
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < NREG; i++) rf[i] = $urandom;
      rf[2] = 32'd42;
      for (int j = 0; j < MW; j++) memw[j] = 8'($urandom);
      stop = (halt_at >= 0 && halt_at < MAXC) ? halt_at : MAXC - 1;
      bus.out_ready = 1'b1;
      phase = 0;
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_last", 32'(bus.out_last), 0);
      check("rst_tag", 32'(bus.out_tag), 0);
      check("rst_data", bus.out_data, 0);
      check("rst_rf_addr", 32'(rf_addr_o), 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_flags", {29'b0, halted_o, timeout_o, done_o}, 0);
      reset = 1'b0;
      phase = 1;
      for (int c = 0; c <= stop; c++) begin
         p = randpc ? ($urandom & ~32'h3) : base + 32'(4 * c);
         pc_i = p;
         inst_i = (c == halt_at) ? 32'h0 : ($urandom | 32'h1);
         pcs.push_back(p);
         @(posedge clk); #1;
      end
      pc_i = $urandom;
      inst_i = 32'h0;
      n = (stop + 1 < DEPTH) ? stop + 1 : DEPTH;
      q.delete();
      for (int i = stop + 1 - n; i <= stop; i++) q.push_back('{pcs[i], 2'd0});
      for (int i = 0; i < NREG; i++) q.push_back('{rf[i], 2'd1});
      for (int j = 0; j < MW; j++) q.push_back('{32'(memw[j]), 2'd2});
      mdl_len = q.size();
      mdl_first = q[0].d;
      mdl_lastpc = q[n-1].d;
      mdl_reg2 = q[n+2].d;
      exp_h = (halt_at >= 0 && halt_at < MAXC);
      exp_t = (stop == MAXC - 1);
      beats = 0;
      phase = 2;
      elapsed = 0;
      while (q.size() != 0 && elapsed < 3000) begin
         if (abort_at >= 0 && beats == abort_at) break;
         bus.out_ready = (mode == 0) ? 1'b1 :
                         (mode == 1) ? pat[elapsed % 4] : 1'($urandom);
         @(posedge clk); #1;
         elapsed++;
      end
      if (abort_at >= 0 && beats == abort_at && q.size() != 0) begin
         check("abort_rf_addr", 32'(rf_addr_o), 10);
         reset = 1'b1;
         phase = 0;
         q.delete();
         @(posedge clk); #1;
         check("abort_valid", 32'(bus.out_valid), 0);
         check("abort_last", 32'(bus.out_last), 0);
         check("abort_rf_addr0", 32'(rf_addr_o), 0);
         check("abort_flags", {29'b0, halted_o, timeout_o, done_o}, 0);
         return;
      end
      if (q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL dump_bound: %0d beats left, expected 0", q.size());
      end else begin
         if (mode == 0) check("dump_cycles", elapsed, mdl_len);
         check("done_after_last", 32'(done_o), 1);
      end
      @(posedge clk); #1;
      phase = 0;
   endtask

   initial begin
      bus.out_ready = 1'b1;
      pc_i = '0;
      inst_i = 32'h1;
      repeat (2) @(posedge clk);
      #1;
      run_case(5, 32'h0, 0, -1, 0);
      check("m_halt_len", mdl_len, 42);
      check("m_halt_first", mdl_first, 32'h0);
      check("m_halt_lastpc", mdl_lastpc, 32'h14);
      check("m_halt_r2", mdl_reg2, 42);
      run_case(-1, 32'h100, 0, -1, 0);
      check("m_to_len", mdl_len, 52);
      check("m_to_first", mdl_first, 32'h100 + 48 * 4);
      run_case(20, 32'h0, 1, -1, 1);
      run_case(63, 32'h200, 2, -1, 0);
      check("m_both", {30'b0, exp_h, exp_t}, 3);
      run_case(9, 32'h0, 0, 20, 0);
      run_case(7, 32'h0, 2, -1, 1);
      run_case(15, 32'h0, 0, -1, 0);
      check("m_full_first", mdl_first, 32'h0);
      check("m_full_len", mdl_len, 52);
      run_case(16, 32'h0, 0, -1, 0);
      check("m_wrap_first", mdl_first, 32'h4);
      run_case(0, 32'h80, 0, -1, 0);
      check("m_single_len", mdl_len, 37);
      repeat (4)
         run_case($urandom_range(0, 80), $urandom & ~32'h3, 2, -1,
                  1'($urandom));
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/run_dump_controller.md
# run_dump_controller

Synthesizable end-of-run capture engine for the single-cycle datapath. It watches the fetched PC and instruction every cycle and records a PC trace in a circular buffer. On a halt (all-zero instruction) or a cycle-budget timeout, it streams the trace, a register-file snapshot and a data-memory window over a valid/ready port. It sits beside `machine` as a hardware replacement for the bench-side PC/register/memory dump, generalised in register count, memory window, trace depth and run budget.

## Interface
- `WIDTH`, 32, PC/register/stream data width
- `NUM_REGS`, 32, registers dumped (index 0..NUM_REGS-1)
- `MEM_BASE`, 32'h4000, first data-memory address dumped
- `MEM_WORDS`, 4, memory entries dumped
- `MEM_DW`, 8, memory read data width (≤ WIDTH)
- `TRACE_DEPTH`, 16, PC trace entries (power of two, ≥2)
- `MAX_CYCLES`, 64, run cycles before forced stop (≥1)

- `clk`  in  1  clock; one clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `pc`  in  WIDTH  current PC (byte address)
- `inst`  in  32  current fetched instruction
- `rf_addr`  out  $clog2(NUM_REGS)  register read index
- `rf_data`  in  WIDTH  combinational read of `rf_addr`
- `mem_addr`  out  WIDTH  memory read address
- `mem_data`  in  MEM_DW  combinational read of `mem_addr`
- `out_valid`  out  1  stream beat valid
- `out_ready`  in  1  consumer accepts beat
- `out_data`  out  WIDTH  beat payload
- `out_tag`  out  2  0=PC trace, 1=register, 2=memory
- `out_last`  out  1  final beat of dump
- `halted`  out  1  run ended on `inst == 0`
- `timeout`  out  1  run ended on cycle budget
- `done`  out  1  dump complete

## Operation
- States: RUN → TRACE → REGS → MEMS → DONE. DONE holds until reset.
- RUN, every cycle:
  - Write `pc` at write pointer `wp`, then `wp++` mod TRACE_DEPTH.
  - `count` saturates at TRACE_DEPTH; oldest entry is overwritten when full.
  - `cycles++`.
- Stop conditions:
  - `inst == 32'h0` sets `halted`.
  - `cycles == MAX_CYCLES-1` sets `timeout`.
  - Both true in the same cycle sets both flags.
  - The stopping cycle's PC is recorded. Next state is TRACE.
- TRACE:
  - Emit `count` entries, oldest first.
  - Read index starts at `wp - count` mod TRACE_DEPTH.
  - `out_tag=0`.
- REGS:
  - `rf_addr` = i for i = 0..NUM_REGS-1.
  - `out_data = rf_data`, `out_tag=1`.
- MEMS:
  - `mem_addr = MEM_BASE + j` for j = 0..MEM_WORDS-1.
  - `out_data` = zero-extended `mem_data`, `out_tag=2`.
  - `out_last=1` on j = MEM_WORDS-1. Acceptance of that beat moves the FSM to DONE and sets `done`.
- A beat transfers when `out_valid && out_ready`; the index advances only on transfer.
- `out_valid=1` in TRACE, REGS and MEMS; 0 in RUN and DONE.
- `pc` and `inst` are ignored outside RUN.
- `out_data`, `out_tag` and `out_last` are combinational from state and index. They hold stable while stalled.
- `rf_addr` and `mem_addr` are 0 outside their states.

## Timing
- Reset values:
  - Outputs: `out_valid=0`, `out_last=0`, `out_tag=0`, `out_data=0`, `rf_addr=0`, `mem_addr=0`, `halted=0`, `timeout=0`, `done=0`.
  - Internal: `wp=0`, `count=0`, `cycles=0`, state RUN.
  - Trace RAM is not cleared.
- The first RUN cycle is the first rising edge with `reset` low.
- Stop detected in cycle N: state is TRACE and `out_valid=1` in cycle N+1.
- `halted` and `timeout` assert in cycle N+1 and hold until reset.
- With `out_ready` held high, the dump takes exactly count + NUM_REGS + MEM_WORDS cycles. `done` asserts the cycle after the `out_last` transfer.
- `count ≥ 1` always on exit from RUN, so TRACE is never empty.
- Reset asserted mid-dump aborts the dump: the next cycle is RUN with cleared pointers and flags, and no partial `out_last` is issued.
- Ready deasserted on the `out_last` beat: stall in MEMS, `done` stays 0.

## Structure
- Package `run_dump_pkg`: state enum, tag constants (`TAG_PC`, `TAG_REG`, `TAG_MEM`), `HALT_INST = 32'h0`.
- One sub-module, `trace_ring`: a TRACE_DEPTH×WIDTH circular buffer.
  - Write enable, saturating count, oldest-first read index.
  - Combinational read port.
- Top holds the FSM, cycle counter and dump indices.

## Test plan
- Halt: PC steps 0,4,8,… with `inst=0` at PC 0x14, `out_ready=1`, NUM_REGS=32, MEM_WORDS=4 → tag-0 beats 0x0..0x14 (6 beats), then 32 register beats with r[2]=42 at beat index 8, then 4 memory beats from 0x4000; `out_last` on the final beat; `halted=1`, `timeout=0`.
- Timeout: MAX_CYCLES=64, TRACE_DEPTH=16, `inst` never 0 → `timeout=1` and exactly 16 trace beats carrying the PCs of run cycles 48..63, oldest first.
- Backpressure: `out_ready` toggles 1,0,0,1 repeatedly → payload is stable during stalls, no beat is lost or duplicated, and the total beat count is unchanged.
- Simultaneous stop: `inst=0` in cycle MAX_CYCLES-1 → both `halted` and `timeout` are 1.
- Reset during REGS at i=10 → next cycle state RUN, `out_valid=0`, all flags 0; a fresh run then dumps correctly.
- Wrap boundary: halt in cycle TRACE_DEPTH-1 (exactly full) and in cycle TRACE_DEPTH (one overwrite) → 16 beats each, starting at PC 0x0 and 0x4 respectively.
